// File: rtl/adder_pkg.sv
// Shared types and elaboration-time helpers for the serial chunk adder.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int nsteps(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Step counter width; a single-step configuration still needs one bit.
  function automatic int cnt_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int width, input int chunk);
    return (width >= 2) && (chunk >= 1) && (chunk <= width) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial chunk adder.
interface serial_chunk_adder_if #(parameter int WIDTH = 16);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             overflow_o;

  modport master (output start_i, a_i, b_i, cin_i,
                  input  busy_o, done_o, sum_o, cout_o, overflow_o);
  modport slave  (input  start_i, a_i, b_i, cin_i,
                  output busy_o, done_o, sum_o, cout_o, overflow_o);
endinterface

// File: rtl/serial_chunk_adder_chunk_rca.sv
// Combinational CHUNK-bit ripple-carry adder built from a chain of full-adder cells.
module chunk_rca #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);
  logic [CHUNK:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o     = c[CHUNK];
  // Carry into the top bit of this chunk; on the last step that is the sum MSB.
  assign c_msb_in_o = c[CHUNK-1];
endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands plus carry-in, CHUNK bits per clock, LSB first.
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_chunk_adder_if.slave bus
);
  localparam int NSTEPS = nsteps(WIDTH, CHUNK);
  localparam int CW     = cnt_width(WIDTH, CHUNK);

  if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("serial_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;

  logic [CHUNK-1:0] rca_s;
  logic             rca_cout, rca_cmsb;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_d;

  chunk_rca #(.CHUNK(CHUNK)) u_rca (
    .a_i        (a_q[CHUNK-1:0]),
    .b_i        (b_q[CHUNK-1:0]),
    .cin_i      (carry_q),
    .s_o        (rca_s),
    .cout_o     (rca_cout),
    .c_msb_in_o (rca_cmsb)
  );

  assign chunk_sum = {rca_cout, rca_s};
  // New chunk enters at the top; after NSTEPS shifts the first chunk sits at bit 0.
  assign res_d = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            a_q     <= bus.a_i;
            b_q     <= bus.b_i;
            carry_q <= bus.cin_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          res_q   <= res_d;
          carry_q <= chunk_sum[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(NSTEPS - 1)) begin
            sum_q   <= res_d;
            cout_q  <= chunk_sum[CHUNK];
            ovf_q   <= rca_cmsb ^ chunk_sum[CHUNK];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.sum_o      = sum_q;
  assign bus.cout_o     = cout_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: default config plus three parameter variants.
module tb_serial_chunk_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_chunk_adder_if #(.WIDTH(16)) b16 ();
  serial_chunk_adder_if #(.WIDTH(8))  b88 ();
  serial_chunk_adder_if #(.WIDTH(8))  b81 ();
  serial_chunk_adder_if #(.WIDTH(32)) b32 ();

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  serial_chunk_adder #(.WIDTH(8),  .CHUNK(8)) dut88 (.clk(clk), .rst(rst), .bus(b88));
  serial_chunk_adder #(.WIDTH(8),  .CHUNK(1)) dut81 (.clk(clk), .rst(rst), .bus(b81));
  serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));

  // Drives one start pulse on the 16-bit DUT and waits for done; lat counts edges after accept.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      output int lat, output int bcnt, output logic both);
    @(negedge clk);
    b16.a_i = a; b16.b_i = b; b16.cin_i = c; b16.start_i = 1'b1;
    @(negedge clk);
    b16.start_i = 1'b0;
    lat = 0; bcnt = 0; both = 1'b0;
    while (b16.done_o !== 1'b1 && lat < 40) begin
      if (b16.busy_o === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    both = b16.busy_o & b16.done_o;
  endtask

  task automatic test_reset;
    b16.start_i = 0; b16.a_i = 0; b16.b_i = 0; b16.cin_i = 0;
    b88.start_i = 0; b88.a_i = 0; b88.b_i = 0; b88.cin_i = 0;
    b81.start_i = 0; b81.a_i = 0; b81.b_i = 0; b81.cin_i = 0;
    b32.start_i = 0; b32.a_i = 0; b32.b_i = 0; b32.cin_i = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({b16.busy_o, b16.done_o, b16.cout_o, b16.overflow_o} !== 4'b0000 || b16.sum_o !== 16'h0) begin
      errs++; $display("FAIL reset16: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                       b16.busy_o, b16.done_o, b16.sum_o, b16.cout_o, b16.overflow_o);
    end
    checks++;
    if ({b88.busy_o, b81.busy_o, b32.busy_o, b88.done_o, b81.done_o, b32.done_o} !== 6'b0 ||
        b88.sum_o !== 8'h0 || b81.sum_o !== 8'h0 || b32.sum_o !== 32'h0) begin
      errs++; $display("FAIL reset_variants: busy/done/sum not zero, want all 0");
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bcnt; logic both;
    op16(16'h00FF, 16'h0001, 1'b0, lat, bcnt, both);
    checks++;
    if (b16.sum_o !== 16'h0100 || b16.cout_o !== 1'b0 || b16.overflow_o !== 1'b0) begin
      errs++; $display("FAIL basic_sum: got %h/%b/%b want 0100/0/0", b16.sum_o, b16.cout_o, b16.overflow_o);
    end
    checks++;
    if (lat !== 4) begin errs++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++;
    if (bcnt !== 4) begin errs++; $display("FAIL basic_busy_cycles: got %0d want 4", bcnt); end
    checks++;
    if (both !== 1'b0) begin errs++; $display("FAIL basic_busy_and_done: busy high with done"); end
    @(negedge clk);
    checks++;
    if (b16.done_o !== 1'b0 || b16.sum_o !== 16'h0100) begin
      errs++; $display("FAIL basic_hold: done=%b sum=%h want 0/0100", b16.done_o, b16.sum_o);
    end
  endtask

  task automatic test_carry_overflow;
    int lat, bcnt; logic both;
    op16(16'hFFFF, 16'h0001, 1'b0, lat, bcnt, both);
    checks++;
    if (b16.sum_o !== 16'h0000 || b16.cout_o !== 1'b1 || b16.overflow_o !== 1'b0 || lat !== 4) begin
      errs++; $display("FAIL carry_out: got %h/%b/%b lat=%0d want 0000/1/0 lat=4",
                       b16.sum_o, b16.cout_o, b16.overflow_o, lat);
    end
    op16(16'h7FFF, 16'h0000, 1'b1, lat, bcnt, both);
    checks++;
    if (b16.sum_o !== 16'h8000 || b16.cout_o !== 1'b0 || b16.overflow_o !== 1'b1 || lat !== 4) begin
      errs++; $display("FAIL overflow: got %h/%b/%b lat=%0d want 8000/0/1 lat=4",
                       b16.sum_o, b16.cout_o, b16.overflow_o, lat);
    end
  endtask

  task automatic test_busy_protect;
    int lat, ndone;
    @(negedge clk);
    b16.a_i = 16'h1234; b16.b_i = 16'h1111; b16.cin_i = 1'b0; b16.start_i = 1'b1;
    @(negedge clk);
    b16.start_i = 1'b0;
    @(negedge clk);
    b16.a_i = 16'hFFFF; b16.b_i = 16'hFFFF; b16.cin_i = 1'b1; b16.start_i = 1'b1;
    @(negedge clk);
    b16.start_i = 1'b0;
    lat = 2;
    while (b16.done_o !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (b16.sum_o !== 16'h2345 || b16.cout_o !== 1'b0 || b16.overflow_o !== 1'b0 || lat !== 4) begin
      errs++; $display("FAIL busy_protect: got %h/%b/%b lat=%0d want 2345/0/0 lat=4",
                       b16.sum_o, b16.cout_o, b16.overflow_o, lat);
    end
    ndone = 0;
    repeat (10) begin @(negedge clk); if (b16.done_o === 1'b1) ndone++; end
    checks++;
    if (ndone !== 0 || b16.busy_o !== 1'b0) begin
      errs++; $display("FAIL busy_protect_extra: extra done=%0d busy=%b want 0/0", ndone, b16.busy_o);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, bcnt, ndone; logic both;
    @(negedge clk);
    b16.a_i = 16'h0F0F; b16.b_i = 16'h0101; b16.cin_i = 1'b0; b16.start_i = 1'b1;
    @(negedge clk);
    b16.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({b16.busy_o, b16.done_o, b16.cout_o, b16.overflow_o} !== 4'b0000 || b16.sum_o !== 16'h0) begin
      errs++; $display("FAIL reset_mid_run: busy=%b done=%b sum=%h want 0/0/0000",
                       b16.busy_o, b16.done_o, b16.sum_o);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin @(negedge clk); if (b16.done_o === 1'b1) ndone++; end
    checks++;
    if (ndone !== 0) begin errs++; $display("FAIL reset_no_done: got %0d done pulses want 0", ndone); end
    op16(16'h8000, 16'h8000, 1'b0, lat, bcnt, both);
    checks++;
    if (b16.sum_o !== 16'h0000 || b16.cout_o !== 1'b1 || b16.overflow_o !== 1'b1 || lat !== 4) begin
      errs++; $display("FAIL after_reset: got %h/%b/%b lat=%0d want 0000/1/1 lat=4",
                       b16.sum_o, b16.cout_o, b16.overflow_o, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] va [3] = '{16'h0001, 16'hABCD, 16'h8000};
    logic [15:0] vb [3] = '{16'h0002, 16'h1111, 16'hFFFF};
    logic        vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [17:0] exp [3] = '{{2'b00, 16'h0003}, {2'b00, 16'hBCDF}, {2'b11, 16'h7FFF}};
    int idx, cyc, last;
    @(negedge clk);
    b16.a_i = va[0]; b16.b_i = vb[0]; b16.cin_i = vc[0]; b16.start_i = 1'b1;
    idx = 0; cyc = 0; last = -1;
    while (idx < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (b16.done_o === 1'b1) begin
        checks++;
        if ({b16.cout_o, b16.overflow_o, b16.sum_o} !== exp[idx]) begin
          errs++; $display("FAIL b2b_result%0d: got %b/%b/%h want %h", idx,
                           b16.cout_o, b16.overflow_o, b16.sum_o, exp[idx]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 5) begin
            errs++; $display("FAIL b2b_spacing%0d: got %0d want 5", idx, cyc - last);
          end
        end
        last = cyc;
        idx++;
        if (idx < 3) begin
          b16.a_i = va[idx]; b16.b_i = vb[idx]; b16.cin_i = vc[idx];
        end else b16.start_i = 1'b0;
      end
    end
    b16.start_i = 1'b0;
    checks++;
    if (idx !== 3) begin errs++; $display("FAIL b2b_count: got %0d done pulses want 3", idx); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_param_sweep;
    logic [31:0] a, b; logic c;
    logic [8:0]  e88, e81; logic [32:0] e32;
    logic        o88, o81, o32;
    int l88, l81, l32;
    logic [9:0]  g88, g81; logic [33:0] g32;
    for (int v = 0; v < 6; v++) begin
      if (v == 0) begin a = 32'hFFFF_FFFF; b = 32'h0; c = 1'b1; end
      else if (v == 1) begin a = 32'h8080_8080; b = 32'h8080_8080; c = 1'b0; end
      else begin a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1)); end
      @(negedge clk);
      b88.a_i = a[7:0]; b88.b_i = b[7:0]; b88.cin_i = c; b88.start_i = 1'b1;
      b81.a_i = a[7:0]; b81.b_i = b[7:0]; b81.cin_i = c; b81.start_i = 1'b1;
      b32.a_i = a;      b32.b_i = b;      b32.cin_i = c; b32.start_i = 1'b1;
      @(negedge clk);
      b88.start_i = 1'b0; b81.start_i = 1'b0; b32.start_i = 1'b0;
      l88 = -1; l81 = -1; l32 = -1;
      for (int t = 0; t < 12; t++) begin
        if (b88.done_o === 1'b1 && l88 < 0) begin l88 = t; g88 = {b88.cout_o, b88.overflow_o, b88.sum_o}; end
        if (b81.done_o === 1'b1 && l81 < 0) begin l81 = t; g81 = {b81.cout_o, b81.overflow_o, b81.sum_o}; end
        if (b32.done_o === 1'b1 && l32 < 0) begin l32 = t; g32 = {b32.cout_o, b32.overflow_o, b32.sum_o}; end
        @(negedge clk);
      end
      e88 = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h0, c};
      o88 = (a[7] == b[7]) && (e88[7] != a[7]);
      e81 = e88; o81 = o88;
      e32 = {1'b0, a} + {1'b0, b} + {32'h0, c};
      o32 = (a[31] == b[31]) && (e32[31] != a[31]);
      checks++;
      if (l88 !== 1 || g88 !== {e88[8], o88, e88[7:0]}) begin
        errs++; $display("FAIL sweep_w8c8 v%0d: lat=%0d got %h want lat=1 %h", v, l88, g88, {e88[8], o88, e88[7:0]});
      end
      checks++;
      if (l81 !== 8 || g81 !== {e81[8], o81, e81[7:0]}) begin
        errs++; $display("FAIL sweep_w8c1 v%0d: lat=%0d got %h want lat=8 %h", v, l81, g81, {e81[8], o81, e81[7:0]});
      end
      checks++;
      if (l32 !== 4 || g32 !== {e32[32], o32, e32[31:0]}) begin
        errs++; $display("FAIL sweep_w32c8 v%0d: lat=%0d got %h want lat=4 %h", v, l32, g32, {e32[32], o32, e32[31:0]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_overflow();
    test_busy_protect();
    test_reset_mid_run();
    test_back_to_back();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/serial_chunk_adder.md
# serial_chunk_adder

Multi-cycle parametrised adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, LSB chunk first. It is the sequential, parametrised successor to the combinational half/full adders in the Adders library. It targets wide additions where a single-cycle ripple path would limit clock rate. A start/busy/done handshake lets a controller or testbench drive it directly.

## Interface
- WIDTH, default 16: operand and sum width in bits; must be ≥ 2.
- CHUNK, default 4: bits added per clock; must divide WIDTH; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- cin  in  1  carry-in; sampled on the accepting edge only.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse; sum, cout and overflow are valid from this cycle.
- sum  out  WIDTH  result, (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry out of the MSB.
- overflow  out  1  two's-complement overflow: carry into the MSB XOR cout.

## Operation
- NSTEPS = WIDTH/CHUNK.
- States:
  - IDLE: after reset.
  - RUN: NSTEPS cycles.
  - DONE: exactly one cycle.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DONE after step NSTEPS-1.
  - DONE→RUN on start.
  - DONE→IDLE otherwise.
- Accept: on an edge with start=1 and state ∈ {IDLE, DONE}:
  - latch a, b into operand shift registers;
  - set the carry register to cin;
  - clear the step counter.
- RUN step i:
  - add bits [i*CHUNK +: CHUNK] of A and B with the carry register;
  - write the CHUNK-bit result into the internal result shift register;
  - update the carry register with the chunk carry-out.
- At step NSTEPS-1, also capture the carry into the MSB (bit WIDTH-2 → WIDTH-1) for overflow.
- Output registers sum, cout and overflow load only on the RUN→DONE edge. They hold until the next completion, so the outputs never show partial results.
- start while busy=1 is ignored: no latch, no effect on the operation in progress.
- Width rules:
  - internal chunk sum is CHUNK+1 bits;
  - the step counter is clog2(NSTEPS) bits, minimum 1;
  - CHUNK=WIDTH gives NSTEPS=1.
- Reset, asynchronous and at any time including mid-RUN:
  - state → IDLE;
  - busy=0, done=0, sum=0, cout=0, overflow=0;
  - the in-progress addition is discarded.
- No stall or backpressure: done is a pulse; the consumer must capture or use the held outputs.

## Timing
- Latency: start accepted at edge k ⇒ busy=1 after edges k … k+NSTEPS-1; done=1 and busy=0 after edge k+NSTEPS. Results are valid in that same cycle.
- With the default parameters (WIDTH=16, CHUNK=4), done follows accept by 4 cycles.
- Back-to-back: start held high through DONE is accepted on the DONE cycle's edge. Throughput is one result per NSTEPS+1 cycles.
- busy and done are never high together; both are registered outputs (no combinational path from inputs).
- Critical path: one CHUNK-bit ripple plus carry-register setup.

## Structure
- Shared package adder_pkg:
  - state typedef (IDLE, RUN, DONE);
  - function computing NSTEPS and counter width;
  - parameter legality checks (elaboration-time assertion that WIDTH % CHUNK == 0).
- Sub-module chunk_rca: a combinational CHUNK-bit ripple-carry adder (a, b, cin → s, cout, c_msb_in), chained from full-adder cells of the library. Instantiate it once; the top holds the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=16, CHUNK=4: a=0x00FF, b=0x0001, cin=0 → sum=0x0100, cout=0, overflow=0; done exactly 4 cycles after accept; busy high 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Then a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, overflow=1.
- Busy protection: pulse start with a=0x1234, b=0x1111, then pulse start with a=0xFFFF, b=0xFFFF during RUN → sum=0x2345; exactly one done pulse.
- Reset at the second RUN cycle → all outputs 0 immediately; no done pulse. A fresh start of a=0x8000, b=0x8000 → sum=0x0000, cout=1, overflow=1.
- Back-to-back: start held high for 3 operations → done pulses spaced 5 cycles apart, each with the correct result.
- Parameter sweep with random operands and cin against a reference model; each configuration checks done latency = NSTEPS.
  - WIDTH=8, CHUNK=8: 1 cycle.
  - WIDTH=8, CHUNK=1: 8 cycles.
  - WIDTH=32, CHUNK=8: 4 cycles.
